// File: rtl/mini_pkg.sv
// Shared definitions for the switch-capture block.
//   - Default widths and debounce length used by sw_debounce / sw_capture.
//   - cap_state_t: write-stage FSM states.
package mini_pkg;

  localparam int SW_W_DEFAULT            = 10;
  localparam int ADDR_W_DEFAULT          = 4;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } cap_state_t;

endpackage : mini_pkg

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a stability counter.
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   sw_i     - asynchronous raw switch bank
//   cand_o   - current candidate value (last synchronized value seen)
//   stable_o - candidate has been held for DEBOUNCE_CYCLES cycles
module sw_debounce
  import mini_pkg::*;
#(
  parameter int SW_W            = SW_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_i,
  output logic [SW_W-1:0] cand_o,
  output logic            stable_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0]  sync1_q, sync2_q;
  logic [SW_W-1:0]  cand_q,  cand_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Any change of the synchronized value restarts the count; an unchanged
  // value counts up and parks at CNT_MAX.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cand_o   = cand_q;
  assign stable_o = (cnt_q == CNT_MAX);

endmodule : sw_debounce

// File: rtl/sw_capture.sv
// Captures debounced switch values and issues them as valid/ready writes
// to incrementing addresses.
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset
//   sw_in    - asynchronous raw switch bank
//   wr_valid - write request pending (WRITE state)
//   wr_ready - downstream accepts the write (ignored in IDLE)
//   wr_addr  - target address, advances after each accepted write
//   wr_data  - debounced value being written
//   wr_count - saturating count of accepted writes
//   busy     - FSM is not in IDLE
module sw_capture
  import mini_pkg::*;
#(
  parameter int SW_W            = SW_W_DEFAULT,
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW_W-1:0]   sw_in,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [SW_W-1:0]   wr_data,
  output logic [15:0]       wr_count,
  output logic              busy
);

  logic [SW_W-1:0] cand;
  logic            stable;

  sw_debounce #(
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (sw_in),
    .cand_o   (cand),
    .stable_o (stable)
  );

  cap_state_t        state_q,   state_d;
  logic [SW_W-1:0]   wr_data_q, wr_data_d;
  logic [SW_W-1:0]   last_q,    last_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [15:0]       count_q,   count_d;

  always_comb begin
    state_d   = state_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    addr_d    = addr_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        // Only a settled value that differs from the last written one
        // starts a write; wr_ready is not looked at here.
        if (stable && (cand != last_q)) begin
          wr_data_d = cand;
          state_d   = WRITE;
        end
      end
      WRITE: begin
        // wr_data/addr hold until accepted; last updates on acceptance so
        // the next IDLE cycle sees no difference and does not re-issue.
        if (wr_ready) begin
          last_d  = wr_data_q;
          addr_d  = addr_q + ADDR_W'(1);
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_data_q <= '0;
      last_q    <= '0;
      addr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
    end
  end

  assign wr_valid = (state_q == WRITE);
  assign busy     = (state_q != IDLE);
  assign wr_data  = wr_data_q;
  assign wr_addr  = addr_q;
  assign wr_count = count_q;

endmodule : sw_capture

// File: tb/tb_sw_capture.sv
// Self-checking bench for sw_capture with DEBOUNCE_CYCLES=4.
// Reference model: the input is a sequence of per-edge samples; the
// candidate is the sample two edges back, a value is "settled" when the
// last DEBOUNCE_CYCLES candidates agree, and a write is a pending record
// that is retired when wr_ready is seen.
module tb_sw_capture;

  localparam int SW_W = 10;
  localparam int ADDR_W = 4;
  localparam int DC = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [SW_W-1:0]   sw_in = '0;
  logic              wr_ready = 1'b0;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [SW_W-1:0]   wr_data;
  logic [15:0]       wr_count;
  logic              busy;

  sw_capture #(
    .SW_W            (SW_W),
    .ADDR_W          (ADDR_W),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_in    (sw_in),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_count (wr_count),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [SW_W-1:0] samp_h[$];
  logic [SW_W-1:0] cand_h[$];
  bit              m_pend;
  logic [SW_W-1:0] m_data, m_last;
  int              m_addr, m_count;

  function automatic bit m_settled();
    if (cand_h.size() < DC) return 1'b0;
    for (int i = cand_h.size() - DC; i < cand_h.size(); i++)
      if (cand_h[i] != cand_h[cand_h.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit              st;
    logic [SW_W-1:0] cd;
    if (rst) begin
      samp_h = {};
      repeat (3) samp_h.push_back('0);
      cand_h = {};
      cand_h.push_back('0);
      m_pend = 0; m_data = '0; m_last = '0; m_addr = 0; m_count = 0;
      return;
    end
    st = m_settled();
    cd = cand_h[cand_h.size()-1];
    if (m_pend) begin
      if (wr_ready) begin
        m_last  = m_data;
        m_addr  = (m_addr + 1) % (1 << ADDR_W);
        m_count = (m_count < 65535) ? m_count + 1 : 65535;
        m_pend  = 0;
      end
    end else if (st && cd != m_last) begin
      m_data = cd;
      m_pend = 1;
    end
    samp_h.push_back(sw_in);
    cand_h.push_back(samp_h[samp_h.size()-3]);
    while (samp_h.size() > 3)  void'(samp_h.pop_front());
    while (cand_h.size() > DC) void'(cand_h.pop_front());
  endtask

  int valid_seen;

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("wr_valid", 32'(wr_valid), 32'(m_pend));
    check("busy",     32'(busy),     32'(m_pend));
    check("wr_data",  32'(wr_data),  32'(m_data));
    check("wr_addr",  32'(wr_addr),  32'(m_addr));
    check("wr_count", 32'(wr_count), 32'(m_count));
    if (wr_valid) valid_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    // Idle after reset with zero switches: nothing is ever written.
    sw_in = '0; wr_ready = 1'b1;
    do_reset();
    valid_seen = 0;
    run(50);
    check("idle_no_valid", 32'(valid_seen), 32'd0);
    check("idle_count",    32'(wr_count),   32'd0);

    // Single value: latency DC+3, then one accepted write.
    do_reset();
    sw_in = 10'h102;
    run(DC + 2);
    check("lat_before", 32'(wr_valid), 32'd0);
    run(1);
    check("lat_valid",  32'(wr_valid), 32'd1);
    check("lat_data",   32'(wr_data),  32'h102);
    check("lat_addr",   32'(wr_addr),  32'd0);
    run(1);
    check("post_count", 32'(wr_count), 32'd1);
    check("post_addr",  32'(wr_addr),  32'd1);
    run(10);

    // Glitch shorter than the debounce window.
    sw_in = '0;
    run(20);
    valid_seen = 0;
    sw_in = 10'h3FF;
    run(3);
    sw_in = '0;
    run(20);
    check("glitch_no_valid", 32'(valid_seen), 32'd0);

    // Stalled write while the input changes underneath it.
    do_reset();
    wr_ready = 1'b0;
    sw_in = 10'h155;
    run(10);
    sw_in = 10'h2AA;
    run(20);
    check("stall_data", 32'(wr_data), 32'h155);
    wr_ready = 1'b1;
    run(20);
    check("stall_count", 32'(wr_count), 32'd2);
    check("stall_last",  32'(wr_data),  32'h2AA);

    // 17 distinct values: address wraps past 15.
    do_reset();
    for (int v = 1; v <= 17; v++) begin
      sw_in = SW_W'(v);
      run(DC + 6);
    end
    check("wrap_count", 32'(wr_count), 32'd17);
    check("wrap_addr",  32'(wr_addr),  32'd1);

    // Reset in the middle of a pending write.
    wr_ready = 1'b0;
    sw_in = 10'h0AB;
    run(DC + 4);
    check("pre_rst_valid", 32'(wr_valid), 32'd1);
    do_reset();
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_addr",  32'(wr_addr),  32'd0);
    check("rst_count", 32'(wr_count), 32'd0);

    // Randomized segments with random ready and occasional reset.
    for (int seg = 0; seg < 400; seg++) begin
      int hold;
      if ($urandom_range(0, 3) != 0) sw_in = SW_W'($urandom);
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        wr_ready = 1'($urandom_range(0, 1));
        rst = ($urandom_range(0, 199) == 0);
        cycle();
      end
      rst = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sw_capture
